// File: rtl/sqrt_fp16_arbiter.sv
// Round-robin share of one non-pipelined fp16 sqrt unit among NUM_REQ requesters; grant->rsp_valid is
// 1 + sqrt accept wait + sqrt latency + 1 cycles; one op in flight, a stalled rsp_ready blocks new grants.
module sqrt_fp16_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*16-1:0] req_operand,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [15:0]           rsp_result,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic                  sq_valid_in,
    output logic [15:0]           sq_operand,
    input  logic                  sq_ready_in,
    input  logic                  sq_valid_out,
    input  logic [15:0]           sq_result,
    output logic                  sq_ready_out,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id,
    output logic [CNT_W-1:0]      done_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] owner;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] cand;
    logic            win_found;
    logic [15:0]     op_q;
    logic            owner_rsp_rdy;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign owner_rsp_rdy = rsp_ready[owner];

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_id] = 1'b1;
                    state_nxt         = ISSUE;
                end
            end
            ISSUE: begin
                if (sq_ready_in) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (sq_valid_out) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (owner_rsp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    // Operand is only presented while issuing so the sqrt input is quiet otherwise.
    assign sq_valid_in  = (state == ISSUE);
    assign sq_operand   = (state == ISSUE) ? op_q : '0;
    assign sq_ready_out = (state == WAIT);
    assign busy         = (state != IDLE);
    assign grant_id     = busy ? owner : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            op_q       <= '0;
            rsp_result <= '0;
            done_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && win_found) begin
                owner  <= win_id;
                op_q   <= req_operand[{win_id, 4'b0000} +: 16];
                rr_ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
            end
            if (state == WAIT && sq_valid_out) begin
                rsp_result <= sq_result;
            end
            if (state == RESP && owner_rsp_rdy) begin
                done_count <= done_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_fp16_arbiter.sv
// Bench for sqrt_fp16_arbiter: a stand-in sqrt unit with programmable latency/stall, and a
// transaction-level reference (pending lanes, round-robin pointer, one outstanding op).
module tb_sqrt_fp16_arbiter;
    localparam int N = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic [N-1:0]  req_valid;
    logic [N*16-1:0] req_operand;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [15:0]   rsp_result;
    logic [N-1:0]  rsp_ready;
    logic          sq_valid_in;
    logic [15:0]   sq_operand;
    logic          sq_ready_in;
    logic          sq_valid_out;
    logic [15:0]   sq_result;
    logic          sq_ready_out;
    logic          busy;
    logic [1:0]    grant_id;
    logic [15:0]   done_count;

    always #5 CLK = ~CLK;

    sqrt_fp16_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_operand(req_operand), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_ready(rsp_ready),
        .sq_valid_in(sq_valid_in), .sq_operand(sq_operand), .sq_ready_in(sq_ready_in),
        .sq_valid_out(sq_valid_out), .sq_result(sq_result), .sq_ready_out(sq_ready_out),
        .busy(busy), .grant_id(grant_id), .done_count(done_count)
    );

    int vectors = 0;
    int errors  = 0;

    // sqrt stand-in state and knobs
    int lat = 2;
    int stall_left = 0;
    int issue_cnt = 0;
    int sq_st = 0;
    int sq_cnt = 0;
    logic [15:0] sq_op = '0;

    // reference model state
    bit [N-1:0]  pend = '0;
    bit [N-1:0]  rearm = '0;
    logic [15:0] opv[N];
    int          rsp_hold[N];
    bit          m_busy = 1'b0;
    int          m_phase = 0;
    int          m_owner = 0;
    logic [15:0] m_op = '0;
    int          m_ptr = 0;
    int          m_done = 0;
    int          grants = 0;
    bit          m_rsp_seen = 1'b0;
    int          grant_cyc = 0;
    int          cyc = 0;
    int          last_lat = -1;

    // observations of the DUT
    int          dut_grants[$];
    int          grant_cycs[$];
    int          rsp_lane[$];
    logic [15:0] rsp_val[$];

    function automatic logic [15:0] fake_sqrt(input logic [15:0] x);
        case (x)
            16'h4400: return 16'h4000;
            16'h4C00: return 16'h4400;
            16'h3C00: return 16'h3C00;
            16'h5400: return 16'h4800;
            16'hBC00: return 16'h7D00;
            16'h0000: return 16'h0000;
            default:  return x ^ 16'h5A3C;
        endcase
    endfunction

    function automatic int onehot_id(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stand-in sqrt: accepts when ready, result after lat+1 cycles, holds valid until taken.
    initial begin
        sq_ready_in  = 1'b1;
        sq_valid_out = 1'b0;
        sq_result    = '0;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                sq_st        = 0;
                sq_valid_out = 1'b0;
                sq_ready_in  = 1'b1;
            end else begin
                if (sq_st == 3) begin
                    sq_valid_out = 1'b0;
                    sq_st        = 0;
                end
                if (sq_st == 0) begin
                    sq_ready_in = !(sq_valid_in && stall_left > 0);
                    if (sq_valid_in && stall_left > 0) stall_left--;
                    if (sq_valid_in && sq_ready_in) begin
                        sq_op  = sq_operand;
                        sq_cnt = lat;
                        sq_st  = 1;
                        issue_cnt++;
                    end
                end else if (sq_st == 1) begin
                    sq_ready_in = 1'b0;
                    if (sq_cnt == 0) begin
                        sq_valid_out = 1'b1;
                        sq_result    = fake_sqrt(sq_op);
                        sq_st        = 2;
                    end else begin
                        sq_cnt--;
                    end
                end
                if (sq_st == 2 && sq_ready_out) sq_st = 3;
            end
        end
    end

    task automatic cycle();
        logic [N-1:0]    exp_rdy;
        logic [N*16-1:0] ops;
        int              w;
        @(negedge CLK);
        cyc++;
        req_valid = pend;
        for (int i = 0; i < N; i++) ops[i*16 +: 16] = opv[i];
        req_operand = ops;
        rsp_ready = 4'($urandom);
        if (m_busy) rsp_ready[2'(m_owner)] = 1'b0;
        #1;
        w = -1;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        exp_rdy = (w >= 0) ? (4'(1) << w) : 4'(0);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (|req_ready) begin
            dut_grants.push_back(onehot_id(req_ready));
            grant_cycs.push_back(cyc);
        end
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), m_busy ? m_owner : 0);
        chk("done_count", 32'(done_count), m_done & 32'hFFFF);
        chk("sq_valid_in", 32'(sq_valid_in), 32'(m_phase == 1));
        if (m_phase == 1) chk("sq_operand", 32'(sq_operand), 32'(m_op));
        if (m_phase != 2) begin
            chk("rsp_none", 32'(rsp_valid), 32'(0));
        end else if (|rsp_valid) begin
            chk("rsp_lane", 32'(rsp_valid), 32'(4'(1) << m_owner));
            chk("rsp_result", 32'(rsp_result), 32'(fake_sqrt(m_op)));
            if (!m_rsp_seen) begin
                m_rsp_seen = 1'b1;
                last_lat   = cyc - grant_cyc;
            end
            if (rsp_hold[m_owner] > 0) begin
                rsp_hold[m_owner]--;
            end else begin
                rsp_ready[2'(m_owner)] = 1'b1;
                rsp_lane.push_back(m_owner);
                rsp_val.push_back(rsp_result);
                m_busy  = 1'b0;
                m_phase = 0;
                m_done++;
            end
        end
        if (m_phase == 1 && sq_ready_in) m_phase = 2;
        if (w >= 0) begin
            m_busy     = 1'b1;
            m_owner    = w;
            m_op       = opv[w];
            m_ptr      = (w + 1) % N;
            m_phase    = 1;
            m_rsp_seen = 1'b0;
            grant_cyc  = cyc;
            grants++;
            if (!rearm[w]) begin
                pend[w] = 1'b0;
                opv[w]  = 16'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2;
        nRST      = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_result", 32'(rsp_result), 32'(0));
        chk("rst_sq_valid_in", 32'(sq_valid_in), 32'(0));
        chk("rst_sq_operand", 32'(sq_operand), 32'(0));
        chk("rst_sq_ready_out", 32'(sq_ready_out), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_grant_id", 32'(grant_id), 32'(0));
        chk("rst_done_count", 32'(done_count), 32'(0));
        pend = '0; rearm = '0;
        m_busy = 1'b0; m_phase = 0; m_ptr = 0; m_done = 0;
        stall_left = 0;
        for (int i = 0; i < N; i++) rsp_hold[i] = 0;
        repeat (2) cycle();
        nRST = 1'b1;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((m_busy || |pend) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk("drain_done", 32'(m_busy || |pend), 32'(0));
    endtask

    task automatic clear_logs();
        dut_grants.delete();
        grant_cycs.delete();
        rsp_lane.delete();
        rsp_val.delete();
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [15:0] exp_res[4] = '{16'h4000, 16'h4400, 16'h3C00, 16'h4800};
    int n_wait;

    initial begin
        nRST = 1'b0;
        req_valid = '0;
        req_operand = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            opv[i] = '0;
            rsp_hold[i] = 0;
        end

        // single request
        do_reset();
        clear_logs();
        opv[0] = 16'h4400;
        pend   = 4'b0001;
        drain(50);
        cycle();
        chk("t1_grant", dut_grants.size() == 1 ? dut_grants[0] : -1, 0);
        chk("t1_rsp_lane", rsp_lane.size() > 0 ? rsp_lane[0] : -1, 0);
        chk("t1_rsp_val", rsp_val.size() > 0 ? 32'(rsp_val[0]) : 32'hFFFF_FFFF, 32'h4000);
        chk("t1_latency", last_lat, 5);
        chk("t1_done", 32'(done_count), 32'(1));

        // all four lanes continuously valid from reset
        do_reset();
        clear_logs();
        opv[0] = 16'h4400; opv[1] = 16'h4C00; opv[2] = 16'h3C00; opv[3] = 16'h5400;
        pend  = 4'b1111;
        rearm = 4'b1111;
        n_wait = 0;
        while (dut_grants.size() < 5 && n_wait < 200) begin
            cycle();
            n_wait++;
        end
        rearm = '0;
        drain(200);
        for (int i = 0; i < 5; i++)
            chk("t2_order", i < dut_grants.size() ? dut_grants[i] : -1, exp_order[i]);
        for (int i = 0; i < 4; i++) begin
            chk("t2_lane", i < rsp_lane.size() ? rsp_lane[i] : -1, i);
            chk("t2_result", i < rsp_val.size() ? 32'(rsp_val[i]) : 32'hFFFF_FFFF, 32'(exp_res[i]));
        end

        // special operands pass straight through
        clear_logs();
        opv[2] = 16'hBC00;
        pend   = 4'b0100;
        drain(50);
        opv[2] = 16'h0000;
        pend   = 4'b0100;
        drain(50);
        chk("t3_lane", rsp_lane.size() > 0 ? rsp_lane[0] : -1, 2);
        chk("t3_neg", rsp_val.size() > 0 ? 32'(rsp_val[0]) : 32'hFFFF_FFFF, 32'h7D00);
        chk("t3_zero", rsp_val.size() > 1 ? 32'(rsp_val[1]) : 32'hFFFF_FFFF, 32'h0000);

        // response backpressure for 20 cycles
        clear_logs();
        opv[1] = 16'h4C00;
        rsp_hold[1] = 20;
        pend = 4'b0010;
        n_wait = 0;
        while (!m_busy && n_wait < 20) begin
            cycle();
            n_wait++;
        end
        opv[3]  = 16'h5400;
        pend[3] = 1'b1;
        drain(100);
        chk("t4_first", dut_grants.size() > 0 ? dut_grants[0] : -1, 1);
        chk("t4_second", dut_grants.size() > 1 ? dut_grants[1] : -1, 3);
        chk("t4_gap", grant_cycs.size() > 1 ? grant_cycs[1] - grant_cycs[0] : -1, 26);

        // sqrt refuses the operand for 5 cycles
        clear_logs();
        opv[0] = 16'h3C00;
        stall_left = 5;
        pend = 4'b0001;
        drain(50);
        chk("t5_latency", last_lat, 10);
        chk("t5_single_issue", issue_cnt, grants);

        // reset while the sqrt is working
        clear_logs();
        lat = 10;
        opv[0] = 16'h4400;
        pend = 4'b0001;
        n_wait = 0;
        while (m_phase != 2 && n_wait < 20) begin
            cycle();
            n_wait++;
        end
        repeat (2) cycle();
        do_reset();
        clear_logs();
        lat = 2;
        opv[0] = 16'h4C00;
        opv[2] = 16'h5400;
        pend = 4'b0101;
        drain(100);
        cycle();
        chk("t6_ptr_reset", dut_grants.size() > 0 ? dut_grants[0] : -1, 0);
        chk("t6_done", 32'(done_count), 32'(2));

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    opv[i]      = 16'($urandom);
                    pend[i]     = 1'b1;
                    rsp_hold[i] = $urandom_range(0, 3);
                end
            end
            lat = $urandom_range(0, 4);
            if ($urandom_range(0, 15) == 0) stall_left = $urandom_range(0, 3);
            cycle();
        end
        drain(200);
        chk("final_issue_count", issue_cnt, grants);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
